// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl -- unsigned 8x8 -> 16-bit multiply engine built around a
// single 4x4 array multiplier that is time-shared over four nibble products.
//
// Operands are captured on an in_valid/in_ready handshake (IDLE only). The
// four partial products a_lo*b_lo, a_hi*b_lo, a_lo*b_hi and a_hi*b_hi are
// shifted by 0/4/4/8 and summed into a 16-bit accumulator. The result is
// offered on out_valid/out_ready and held until accepted.
//
// Parameters
//   PP_REG    0: accumulate the multiplier output in the same cycle
//             1: register the multiplier output first (one extra DRAIN cycle)
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   a/b valid
//   in_ready   out  1   ready for operands (IDLE only)
//   a, b       in   8   unsigned operands
//   abort      in   1   synchronous cancel of the operation in flight
//   out_valid  out  1   product valid, held until out_ready
//   out_ready  in   1   downstream accepts product
//   product    out  16  unsigned a*b (meaningful only while out_valid=1)
//   busy       out  1   not in IDLE

module array_mult (
  input  logic [3:0] m,
  input  logic [3:0] q,
  output logic [7:0] p
);
  assign p = {4'b0, m} * {4'b0, q};
endmodule

module mult8_seq_ctrl #(
  parameter int unsigned PP_REG = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  step;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc;
  logic [3:0]  mul_m, mul_q;
  logic [7:0]  pp, pp_q;
  logic [3:0]  shift, shift_q;
  logic        pp_vld_q;   // pp_q holds a partial product not yet accumulated

  // Nibble selection and weight for the current step
  always_comb begin
    mul_m = a_q[3:0];
    mul_q = b_q[3:0];
    shift = 4'd0;
    case (step)
      2'd0: begin mul_m = a_q[3:0]; mul_q = b_q[3:0]; shift = 4'd0; end
      2'd1: begin mul_m = a_q[7:4]; mul_q = b_q[3:0]; shift = 4'd4; end
      2'd2: begin mul_m = a_q[3:0]; mul_q = b_q[7:4]; shift = 4'd4; end
      default: begin mul_m = a_q[7:4]; mul_q = b_q[7:4]; shift = 4'd8; end
    endcase
  end

  array_mult u_array_mult (
    .m (mul_m),
    .q (mul_q),
    .p (pp)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort outranks every other request
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!abort && in_valid) state_nxt = MUL;
      MUL: begin
        if (abort)            state_nxt = IDLE;
        else if (step == 2'd3) state_nxt = (PP_REG != 0) ? DRAIN : DONE;
      end
      DRAIN: state_nxt = abort ? IDLE : DONE;
      DONE:  if (abort || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, step counter and shift-accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      acc      <= 16'd0;
      step     <= 2'd0;
      pp_q     <= 8'd0;
      shift_q  <= 4'd0;
      pp_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!abort && in_valid) begin
            a_q      <= a;
            b_q      <= b;
            acc      <= 16'd0;
            step     <= 2'd0;
            pp_vld_q <= 1'b0;
          end
        end
        MUL: begin
          if (abort) begin
            acc      <= 16'd0;
            step     <= 2'd0;
            pp_vld_q <= 1'b0;
          end else begin
            step <= step + 2'd1;
            if (PP_REG == 0) begin
              acc <= acc + ({8'd0, pp} << shift);
            end else begin
              // Accumulate last cycle's registered product while loading the next
              pp_q     <= pp;
              shift_q  <= shift;
              pp_vld_q <= 1'b1;
              if (pp_vld_q) acc <= acc + ({8'd0, pp_q} << shift_q);
            end
          end
        end
        DRAIN: begin
          pp_vld_q <= 1'b0;
          step     <= 2'd0;
          if (abort) acc <= 16'd0;
          else       acc <= acc + ({8'd0, pp_q} << shift_q);
        end
        DONE: begin
          if (abort) begin
            acc  <= 16'd0;
            step <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign product   = acc;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Bench for mult8_seq_ctrl: one instance per PP_REG setting, selected by
// 'sel'. in_valid reaches only the selected instance so the other stays
// idle; all other inputs are shared and outputs are muxed by 'sel'.

module tb_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a_i, b_i;
  logic        abort;
  logic        out_ready;
  logic        sel;

  logic        in_ready0, out_valid0, busy0;
  logic        in_ready1, out_valid1, busy1;
  logic [15:0] product0, product1;

  logic        in_ready_m, out_valid_m, busy_m;
  logic [15:0] product_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult8_seq_ctrl #(.PP_REG(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & ~sel),
    .in_ready  (in_ready0),
    .a         (a_i),
    .b         (b_i),
    .abort     (abort),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .product   (product0),
    .busy      (busy0)
  );

  mult8_seq_ctrl #(.PP_REG(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & sel),
    .in_ready  (in_ready1),
    .a         (a_i),
    .b         (b_i),
    .abort     (abort),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .product   (product1),
    .busy      (busy1)
  );

  assign in_ready_m  = sel ? in_ready1  : in_ready0;
  assign out_valid_m = sel ? out_valid1 : out_valid0;
  assign busy_m      = sel ? busy1      : busy0;
  assign product_m   = sel ? product1   : product0;

  typedef struct {
    logic        s;
    logic [7:0]  av;
    logic [7:0]  bv;
    logic [15:0] exp_p;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; returns cycles counted after the accept edge
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid_m && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Accept one operand pair (out_ready already high) and check the result
  task automatic run_op(input logic s, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp_p);
    int n;
    sel = s;
    out_ready = 1'b1;
    check("in_ready_before_op", in_ready_m, 1);
    a_i = av; b_i = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a_i = ~av; b_i = ~bv;
    wait_valid(n);
    check("latency", n, s ? 5 : 4);
    check("product", product_m, exp_p);
    tick();
    check("out_valid_after_accept", out_valid_m, 0);
    check("in_ready_after_accept", in_ready_m, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [7:0] av, bv, nav, nbv;

    vecs[0] = '{1'b0, 8'd200, 8'd150, 16'h7530};
    vecs[1] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
    vecs[2] = '{1'b0, 8'h00,  8'hA7,  16'h0000};
    vecs[3] = '{1'b0, 8'h0F,  8'hF0,  16'h0E10};
    vecs[4] = '{1'b1, 8'hFF,  8'hFF,  16'hFE01};
    vecs[5] = '{1'b1, 8'h12,  8'h34,  16'h03A8};
    vecs[6] = '{1'b1, 8'hA7,  8'h00,  16'h0000};
    vecs[7] = '{1'b1, 8'h80,  8'h02,  16'h0100};

    sel = 1'b0; rst_n = 1'b0; in_valid = 1'b0; a_i = 8'd0; b_i = 8'd0;
    abort = 1'b0; out_ready = 1'b1;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("reset_in_ready", in_ready_m, 1);
      check("reset_out_valid", out_valid_m, 0);
      check("reset_busy", busy_m, 0);
      check("reset_product", product_m, 0);
    end
    sel = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].s, vecs[i].av, vecs[i].bv, vecs[i].exp_p);

    // Result held while out_ready is low; new operands ignored
    sel = 1'b0;
    out_ready = 1'b0;
    a_i = 8'h12; b_i = 8'h34; in_valid = 1'b1;
    tick();
    a_i = 8'hFF; b_i = 8'hFF;
    wait_valid(n);
    check("hold_latency", n, 4);
    for (int k = 0; k < 10; k++) begin
      check("hold_out_valid", out_valid_m, 1);
      check("hold_product", product_m, 16'h03A8);
      check("hold_in_ready", in_ready_m, 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("hold_release_out_valid", out_valid_m, 0);
    check("hold_release_in_ready", in_ready_m, 1);

    // Async reset at step 2
    a_i = 8'hFF; b_i = 8'h0F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready_m, 1);
    check("rst_mid_busy", busy_m, 0);
    check("rst_mid_out_valid", out_valid_m, 0);
    check("rst_mid_product", product_m, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(1'b0, 8'd3, 8'd5, 16'h000F);

    // abort in IDLE beats in_valid
    abort = 1'b1; a_i = 8'h55; b_i = 8'h66; in_valid = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_idle_busy", busy_m, 0);
    check("abort_idle_in_ready", in_ready_m, 1);

    // abort at step 1
    a_i = 8'hC3; b_i = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_mul_busy", busy_m, 0);
    check("abort_mul_out_valid", out_valid_m, 0);
    check("abort_mul_product", product_m, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("abort_mul_no_valid", out_valid_m, 0);
    end
    run_op(1'b0, 8'd7, 8'd9, 16'd63);

    // abort together with out_ready in DONE
    out_ready = 1'b0;
    a_i = 8'hC3; b_i = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    check("abort_done_reach", out_valid_m, 1);
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_out_valid", out_valid_m, 0);
    check("abort_done_in_ready", in_ready_m, 1);
    check("abort_done_product", product_m, 0);
    run_op(1'b0, 8'd11, 8'd13, 16'd143);

    // PP_REG=1: back-to-back in_valid with random operands
    sel = 1'b1;
    out_ready = 1'b1;
    av = 8'($urandom_range(0, 255));
    bv = 8'($urandom_range(0, 255));
    for (int i = 0; i < 1000; i++) begin
      a_i = av; b_i = bv; in_valid = 1'b1;
      check("rand_in_ready", in_ready_m, 1);
      tick();
      nav = 8'($urandom_range(0, 255));
      nbv = 8'($urandom_range(0, 255));
      a_i = nav; b_i = nbv;
      wait_valid(n);
      check("rand_latency", n, 5);
      check("rand_product", product_m, {8'd0, av} * {8'd0, bv});
      check("rand_busy_in_ready", in_ready_m, 0);
      tick();
      av = nav; bv = nbv;
    end
    in_valid = 1'b0;
    tick();
    check("rand_final_idle", busy_m, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
